pipe_muxn: RTL and testbench
============================

PIPE_MUXN -- requirements
Module: pipe_muxn

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of each input channel and of the output.
REQ-002 SHALL have parameter N, default 4, meaning number of input channels (2..16).
REQ-003 SHALL have localparam SELW = max(1, clog2(N)), meaning select width.
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports listed first:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have the following data and handshake ports:
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when high together with in_valid; driven from a register.
- sel  in  SELW  channel select, sampled with the beat.
- in_data  in  N*WIDTH  flattened channels; channel k is bits [k*WIDTH +: WIDTH].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  selected channel data.
- out_sel  out  SELW  select value that produced out_data.

Function
REQ-006 SHALL transfer an input beat when in_valid and in_ready are both high at a rising clk edge.
REQ-007 SHALL capture in_data channel sel together with sel at the transfer edge; later changes to in_data or sel SHALL NOT affect the captured beat.
REQ-008 SHALL present a captured beat on out_valid/out_data/out_sel starting on the cycle after capture, giving a latency of 1 cycle.
REQ-009 SHALL hold out_data and out_sel stable while out_valid is high and out_ready is low.
REQ-010 SHALL implement a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-011 SHALL drive in_ready = 1 in EMPTY and ONE, and in_ready = 0 in FULL.
REQ-012 SHALL apply the following state transitions, where push = in transfer and pop = out_valid & out_ready:
- EMPTY: on push, go to ONE.
- ONE: on push without pop, go to FULL; on pop without push, go to EMPTY; on push with pop, stay in ONE and load the new beat.
- FULL: on pop, go to ONE, with the skid entry promoted to the output.
REQ-013 SHALL preserve beat order; no beat SHALL be lost or duplicated.
REQ-014 SHALL sustain one beat per cycle when out_ready is held high.
REQ-015 SHALL select channel 0 when sel >= N and PIPE_MUXN_SEL_CHK_EN is undefined, and SHALL report out_sel as the raw sel value.
REQ-016 SHALL ignore in_data and sel when no transfer occurs.

Reset
REQ-017 SHALL, while rst_n is low, asynchronously force state EMPTY, out_valid = 0, in_ready = 0, out_data = 0 and out_sel = 0.
REQ-018 SHALL raise in_ready on the first clk edge after rst_n deasserts.
REQ-019 SHALL discard any in-flight beats when reset is asserted mid-operation.

Configuration
REQ-020 SHALL, when macro PIPE_MUXN_SEL_CHK_EN is defined, add output port sel_err (1 bit, reset 0) and handle an out-of-range select as follows:
- a beat accepted with sel >= N SHALL produce out_data = 0 and set sel_err;
- sel_err SHALL be sticky until reset.
REQ-021 SHALL, when PIPE_MUXN_SEL_CHK_EN is undefined, omit sel_err and behave per REQ-015.
REQ-022 SHALL make the checker a no-op when N is a power of two, with sel_err tied to 0.

Structure
REQ-023 SHALL place the skid-buffer state enum (EMPTY/ONE/FULL) and the clog2 helper in shared package pipe_pkg.
REQ-024 SHALL use one sub-module, skid_buf, parametrised by payload width WIDTH+SELW, holding the handshake/state logic; pipe_muxn SHALL contain the select datapath and the checker.

Verification
REQ-025 SHALL cover the following reset scenario: rst_n low -> out_valid=0, in_ready=0, out_data=0; release -> in_ready=1 after one edge.
REQ-026 SHALL cover the following streaming scenario: N=4, WIDTH=32, out_ready=1, channels {0xA0,0xB1,0xC2,0xD3}, sel=0,1,2,3 on consecutive cycles -> out_data 0xA0,0xB1,0xC2,0xD3 one cycle later, one per cycle.
REQ-027 SHALL cover the following backpressure scenario: out_ready=0, push beats sel=1 then sel=2 -> in_ready=0 after second beat, out_data=0xB1 held; out_ready=1 -> 0xB1 then 0xC2, in_ready returns 1.
REQ-028 SHALL cover the following simultaneous push/pop scenario: in state ONE with push and pop in the same cycle -> state stays ONE and out_data updates to the new beat next cycle.
REQ-029 SHALL cover the following out-of-range scenario: N=3, sel=3 -> out_data = channel 0 without the macro; out_data = 0 and sel_err=1 (sticky) with PIPE_MUXN_SEL_CHK_EN defined.
REQ-030 SHALL cover the following mid-operation reset scenario: rst_n pulsed low while FULL -> out_valid=0 immediately, and after release no stale beat appears.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_pkg                                                    |
// | Description : Shared skid-buffer state encoding and width helpers for     |
// |               the pipelined N-way multiplexer.                            |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Ceiling log2, written with a bounded loop so it elaborates everywhere.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : skid_buf                                                    |
// | Description : Two-entry registered skid buffer (EMPTY/ONE/FULL) carrying  |
// |               an opaque payload with a registered in_ready.              |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module skid_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_push;
    logic             w_pop;
    logic             w_load_out_in;
    logic             w_load_out_skid;
    logic             w_load_skid;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_state_nxt   = ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    w_load_out_in = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = FULL;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_state_nxt     = ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_skid      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != FULL);
            r_out_valid <= (w_state_nxt != EMPTY);
            if (w_load_out_in) begin
                r_out <= in_data;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out;

endmodule
`default_nettype wire

// File: rtl/pipe_muxn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_muxn                                                   |
// | Description : N-way channel select registered through a 2-entry skid     |
// |               buffer. Optional out-of-range select checker enabled by    |
// |               macro PIPE_MUXN_SEL_CHK_EN (adds sticky sel_err output).   |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module pipe_muxn
    import pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel
`ifdef PIPE_MUXN_SEL_CHK_EN
    ,
    output logic               sel_err
`endif
);

    localparam bit c_POW2 = ((N & (N - 1)) == 0);

    logic [WIDTH-1:0]      w_chan_data;
    logic [WIDTH-1:0]      w_payload_data;
    logic                  w_in_ready;
    logic [WIDTH+SELW-1:0] w_pl_in;
    logic [WIDTH+SELW-1:0] w_pl_out;

    // Unmatched selects fall through to channel 0.
    always_comb begin
        w_chan_data = in_data[WIDTH-1:0];
        for (int k = 1; k < N; k++) begin
            if (sel == SELW'(k)) begin
                w_chan_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef PIPE_MUXN_SEL_CHK_EN
    generate
        if (c_POW2) begin : g_chk_off
            assign w_payload_data = w_chan_data;
            assign sel_err        = 1'b0;
        end else begin : g_chk_on
            logic w_sel_oob;
            logic r_sel_err;

            assign w_sel_oob      = (sel > SELW'(N - 1));
            assign w_payload_data = w_sel_oob ? '0 : w_chan_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sel_err <= 1'b0;
                end else if (in_valid && w_in_ready && w_sel_oob) begin
                    r_sel_err <= 1'b1;
                end
            end

            assign sel_err = r_sel_err;
        end
    endgenerate
`else
    assign w_payload_data = w_chan_data;
`endif

    // The raw select travels with the data so out_sel reports what was asked.
    assign w_pl_in = {sel, w_payload_data};

    skid_buf #(
        .WIDTH (WIDTH + SELW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_pl_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_pl_out)
    );

    assign in_ready = w_in_ready;
    assign out_data = w_pl_out[WIDTH-1:0];
    assign out_sel  = w_pl_out[WIDTH +: SELW];

endmodule
`default_nettype wire

// File: tb/tb_pipe_muxn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_muxn                                                |
// | Description : Self-checking bench: queue model for N=4, directed out-of- |
// |               range checks for N=3.                                      |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pipe_muxn;

    localparam int W = 32;
    localparam logic [4*W-1:0] c_CHANS4 = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    localparam logic [3*W-1:0] c_CHANS3 = {32'hC2, 32'hB1, 32'hA0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b1;
    logic [1:0]     sel       = 2'd0;
    logic [4*W-1:0] in_data   = c_CHANS4;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;

    // N=3 instance
    logic           in_valid3 = 1'b0;
    logic [1:0]     sel3      = 2'd0;
    logic [3*W-1:0] in_data3  = c_CHANS3;
    logic           in_ready3;
    logic           out_valid3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_sel3;

`ifdef PIPE_MUXN_SEL_CHK_EN
    logic sel_err;
    logic sel_err3;
`endif

    pipe_muxn #(.WIDTH(W), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef PIPE_MUXN_SEL_CHK_EN
        ,
        .sel_err   (sel_err)
`endif
    );

    pipe_muxn #(.WIDTH(W), .N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (1'b1),
        .out_data  (out_data3),
        .out_sel   (out_sel3)
`ifdef PIPE_MUXN_SEL_CHK_EN
        ,
        .sel_err   (sel_err3)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two beats; ready reflects the
    // occupancy left after the previous edge.
    logic [W-1:0] q_data[$];
    logic [1:0]   q_sel[$];
    bit           m_ready = 1'b0;
    bit           m_push;
    bit           m_pop;

    function automatic logic [W-1:0] pick(input logic [4*W-1:0] d, input logic [1:0] s);
        return d[int'(s)*W +: W];
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q_data.delete();
            q_sel.delete();
            m_ready = 1'b0;
        end else begin
            m_push = in_valid && m_ready;
            m_pop  = (q_data.size() > 0) && out_ready;
            if (m_pop) begin
                void'(q_data.pop_front());
                void'(q_sel.pop_front());
            end
            if (m_push) begin
                q_data.push_back(pick(in_data, sel));
                q_sel.push_back(sel);
            end
            m_ready = (q_data.size() < 2);
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("m_rst_valid", {31'd0, out_valid}, 32'd0);
            chk("m_rst_ready", {31'd0, in_ready}, 32'd0);
            chk("m_rst_data", out_data, 32'd0);
            chk("m_rst_sel", {30'd0, out_sel}, 32'd0);
        end else begin
            chk("m_ready", {31'd0, in_ready}, {31'd0, m_ready});
            chk("m_valid", {31'd0, out_valid}, {31'd0, q_data.size() > 0});
            if (q_data.size() > 0) begin
                chk("m_data", out_data, q_data[0]);
                chk("m_sel", {30'd0, out_sel}, {30'd0, q_sel[0]});
            end
        end
    end

    logic [W-1:0] exp_stream [4];

    initial begin
        exp_stream[0] = 32'hA0;
        exp_stream[1] = 32'hB1;
        exp_stream[2] = 32'hC2;
        exp_stream[3] = 32'hD3;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst3_valid", {31'd0, out_valid3}, 32'd0);
        #1 rst_n = 1'b1;
        #1 chk("ready_pre_edge", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("ready_post_edge", {31'd0, in_ready}, 32'd1);

        // Streaming, one beat per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) chk("stream_data", out_data, exp_stream[i-1]);
            in_valid = 1'b1;
            sel      = 2'(i);
        end
        @(negedge clk);
        chk("stream_data", out_data, 32'hD3);
        in_valid = 1'b0;
        @(negedge clk);

        // Backpressure fills the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        @(negedge clk);
        sel = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        sel      = 2'd3;
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_hold", out_data, 32'hB1);
        @(negedge clk);
        chk("bp_hold2", out_data, 32'hB1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second", out_data, 32'hC2);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Push and pop in the same cycle while holding one beat
        in_valid = 1'b1;
        sel      = 2'd0;
        @(negedge clk);
        sel = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp_data", out_data, 32'hD3);
        chk("pp_ready", {31'd0, in_ready}, 32'd1);
        chk("pp_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);

        // Reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        @(negedge clk);
        sel = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_before_rst", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_data", out_data, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Mixed traffic with changing channel data
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom_range(0, 3));
            in_data   = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        // N=3 with an out-of-range select
`ifdef PIPE_MUXN_SEL_CHK_EN
        chk("err_pre", {31'd0, sel_err3}, 32'd0);
        chk("err_pow2", {31'd0, sel_err}, 32'd0);
`endif
        in_valid3 = 1'b1;
        sel3      = 2'd3;
        @(negedge clk);
        in_valid3 = 1'b0;
        chk("oob_valid", {31'd0, out_valid3}, 32'd1);
        chk("oob_sel", {30'd0, out_sel3}, 32'd3);
`ifdef PIPE_MUXN_SEL_CHK_EN
        chk("oob_data", out_data3, 32'd0);
        chk("oob_err", {31'd0, sel_err3}, 32'd1);
`else
        chk("oob_data", out_data3, 32'hA0);
`endif
        @(negedge clk);
        in_valid3 = 1'b1;
        sel3      = 2'd2;
        @(negedge clk);
        in_valid3 = 1'b0;
        chk("n3_ch2", out_data3, 32'hC2);
        chk("n3_sel2", {30'd0, out_sel3}, 32'd2);
`ifdef PIPE_MUXN_SEL_CHK_EN
        chk("err_sticky", {31'd0, sel_err3}, 32'd1);
`endif
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
